bcd_updown_counter: RTL

Parametrised multi-digit BCD up/down counter, successor to the 4-bit binary counter. Adds per-digit decimal roll-over, direction control, synchronous clear and load, wrap or saturate mode, a cascade terminal-count output and a registered carry/borrow pulse. Drives display and timer blocks directly with packed BCD digits.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_updown_counter_if.sv | 28 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/bcd_updown_counter.sv | 106 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and nibble helper for the up/down counter slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   // True when a nibble holds a legal decimal digit.
   function automatic logic is_bcd(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control and result bundle of the BCD up/down counter.
// Latency: none (wiring only).
// Backpressure: none; the counter accepts a command on every clock edge.
interface bcd_updown_counter_if #(
   parameter int DIGITS = 4
);

   logic                  en;
   logic                  up;
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  tc;
   logic                  carry;
   logic                  err;

   modport master (
      output en, up, clr, load, load_val,
      input  count, tc, carry, err
   );

   modport slave (
      input  en, up, clr, load, load_val,
      output count, tc, carry, err
   );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit with wrap 9->0 / 0->9, clear and parallel load.
// Latency: 1 clock edge from step/clr/ld to q.
// Backpressure: none; the parent gates step and ld.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       up,
   input  logic       clr,
   input  logic       ld,
   input  logic [3:0] ld_val,
   output logic [3:0] q,
   output logic       at_max,
   output logic       at_min
);

   logic [3:0] q_d;
   logic [3:0] q_q;

   // Next digit value: clear beats load beats step; stepping rolls over decimally.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = BCD_MIN;
      end else if (ld) begin
         q_d = ld_val;
      end else if (step) begin
         if (up) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
         end else begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
         end
      end
   end

   // Digit register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= BCD_MIN;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign at_max = (q_q == BCD_MAX);
   assign at_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, checked load, wrap/saturate and cascade tc.
// Latency: 1 edge from en/clr/load to count; carry and err are registered pulses one cycle after the edge.
// Backpressure: none; tc is combinational so a following stage's en can be chained in the same cycle.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
)(
   input  logic             clk,
   input  logic             rst,
   bcd_updown_counter_if.slave bus
);

   localparam int CW = 4 * DIGITS;

   logic [DIGITS-1:0] dig_max;
   logic [DIGITS-1:0] dig_min;
   logic [DIGITS-1:0] dig_step;
   // chain_max[i] / chain_min[i]: every digit below i sits at 9 / 0.
   logic [DIGITS:0]   chain_max;
   logic [DIGITS:0]   chain_min;
   logic [CW-1:0]     count_w;
   logic              ld_ok;
   logic              ld_acc;
   logic              at_limit;
   logic              move;
   logic              carry_d;
   logic              carry_q;
   logic              err_d;
   logic              err_q;

   // Ripple the "all lower digits at the limit" condition up through the digits.
   always_comb begin
      chain_max    = '0;
      chain_min    = '0;
      chain_max[0] = 1'b1;
      chain_min[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         chain_max[i+1] = chain_max[i] & dig_max[i];
         chain_min[i+1] = chain_min[i] & dig_min[i];
      end
   end

   // A load is accepted only when every nibble is a legal decimal digit.
   always_comb begin
      ld_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!is_bcd(bus.load_val[4*i +: 4])) begin
            ld_ok = 1'b0;
         end
      end
   end

   assign at_limit = bus.up ? chain_max[DIGITS] : chain_min[DIGITS];
   assign bus.tc   = bus.en & at_limit;

   // Counting only happens when neither clear nor load claims the edge; saturation freezes the limit.
   assign move   = bus.en & ~bus.clr & ~bus.load & ~(SATURATE && at_limit);
   assign ld_acc = bus.load & ld_ok;

   // Per-digit step enables: a digit moves when all lower digits are at the rollover value.
   always_comb begin
      dig_step = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_step[i] = move & (bus.up ? chain_max[i] : chain_min[i]);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk    (clk),
         .rst    (rst),
         .step   (dig_step[g]),
         .up     (bus.up),
         .clr    (bus.clr),
         .ld     (ld_acc),
         .ld_val (bus.load_val[4*g +: 4]),
         .q      (count_w[4*g +: 4]),
         .at_max (dig_max[g]),
         .at_min (dig_min[g])
      );
   end

   // Pulse sources: carry on an enabled limit edge, err on a rejected load; clear masks both.
   always_comb begin
      carry_d = bus.en & at_limit & ~bus.clr & ~bus.load;
      err_d   = bus.load & ~ld_ok & ~bus.clr;
   end

   // One-cycle pulse registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign bus.count = count_w;
   assign bus.carry = carry_q;
   assign bus.err   = err_q;

endmodule
